latch_input_debouncer: RTL and testbench
========================================

# latch_input_debouncer

Conditions two raw, bouncing pushbutton inputs (set and clear) into clean, glitch-free, active-low set/reset drives for the NAND-style `sr_latch`. It sits directly upstream of `sr_latch`. Its `set_n`/`rst_out_n` outputs connect to the latch `S`/`R` inputs, which are active-low. Each channel is synchronised, then debounced by a counter-based state machine. The block guarantees the latch never sees both inputs asserted at once.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synced samples required to accept a level change; legal range ≥ 2.
- `SYNC_STAGES`, default 2: synchroniser depth; legal range ≥ 2.

Ports:
- `clk`  in  1  single block clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_set_raw`  in  1  raw set button, active-high, asynchronous to `clk`, may bounce.
- `btn_clr_raw`  in  1  raw clear button, same properties.
- `set_n`  out  1  registered, active-low set drive to `sr_latch.S`.
- `rst_out_n`  out  1  registered, active-low reset drive to `sr_latch.R`.
- `set_evt`  out  1  one-cycle pulse when debounced set press is accepted.
- `clr_evt`  out  1  one-cycle pulse when debounced clear press is accepted.
- `conflict`  out  1  high while both debounced channels are pressed.

## Operation
- Each channel runs `SYNC_STAGES` flops, then a `debounce_channel` FSM plus counter. Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- FSM states and transitions:
  - `RELEASED`: moves to `PRESS_WAIT` when synced input = 1; counter cleared.
  - `PRESS_WAIT`: counter increments while synced = 1. If synced = 0, returns to `RELEASED` and counter clears. When counter reaches `DEBOUNCE_CYCLES-1` with synced still 1, moves to `PRESSED`.
  - `PRESSED`: debounced level = 1. Moves to `RELEASE_WAIT` when synced = 0.
  - `RELEASE_WAIT`: mirror of `PRESS_WAIT`. Synced = 1 returns to `PRESSED`. After `DEBOUNCE_CYCLES` consecutive zeros, moves to `RELEASED`.
- Counter is cleared on every state entry and never wraps.
- Output logic, all registered:
  - `set_n` = ~(set_db & ~clr_db)
  - `rst_out_n` = ~(clr_db & ~set_db)
  - `conflict` = set_db & clr_db
  - On conflict, both drives go high, so the latch holds its state.
- `set_evt` is high for exactly the cycle following entry into `PRESSED` on the set channel. `clr_evt` behaves the same for the clear channel. Events fire even during a conflict.
- A bounce shorter than `DEBOUNCE_CYCLES` synced cycles produces no output change and no event.

## Timing
- Reset (async assert, synchronous release via normal flops):
  - All synchroniser flops = 0; FSMs = `RELEASED`; counters = 0.
  - `set_n` = 1, `rst_out_n` = 1, `set_evt` = 0, `clr_evt` = 0, `conflict` = 0.
- Press latency: raw rises before edge k and is held stable. The debounced level is set at edge k + `SYNC_STAGES` + `DEBOUNCE_CYCLES`. `set_n`/`rst_out_n`/`*_evt` change one edge later, so total latency is `SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1 edges.
- Release latency is identical. Release produces no event.
- Both channels accepted on the same edge: `conflict` = 1, both drives high, both events pulse.
- One channel already pressed when the other is accepted: the asserted drive deasserts on the same edge that `conflict` rises.
- Reset asserted mid-count or mid-press: outputs go to reset values immediately, without waiting for `clk`. There is no residual event after release.

## Structure
- Shared package `latch_cond_pkg`:
  - `typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t`
  - `localparam int unsigned DEBOUNCE_MIN = 2`
- Sub-module `debounce_channel`: one synchroniser, FSM, and counter. Outputs the debounced level and a rise pulse. It is instantiated twice. The top level holds only the exclusion logic and output registers.
- Top level carries an elaboration-time check that `DEBOUNCE_CYCLES` ≥ `DEBOUNCE_MIN`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `SYNC_STAGES` = 2.
- Reset check: hold `rst_n` = 0 for 3 cycles -> `set_n` = 1, `rst_out_n` = 1, events = 0, `conflict` = 0.
- Clean set press: `btn_set_raw` 0→1 held -> `set_n` falls and `set_evt` pulses exactly 7 edges later. `set_evt` stays high for exactly 1 cycle.
- Bounce rejection: `btn_set_raw` toggles 1,1,1,0 repeatedly for 40 cycles -> `set_n` stays 1 and `set_evt` never fires. Then hold at 1 -> accepted 7 edges after the last 0.
- Simultaneous press: both raw inputs rise on the same cycle -> after 7 edges, `conflict` = 1, `set_n` = `rst_out_n` = 1, and both events pulse once.
- Overlap: set pressed and accepted (`set_n` = 0), then clear pressed -> on clear acceptance, `set_n` returns to 1 and `conflict` = 1. Release set -> 7 edges later `rst_out_n` = 0 and `conflict` = 0.
- Reset mid-operation: `rst_n` goes low while set is in `PRESS_WAIT` with counter = 2 -> outputs reset immediately. After release, with the raw input still high, acceptance takes a full 7 edges.

Source files
------------

// File: rtl/latch_cond_pkg.sv
// Shared types and limits for the latch input conditioning blocks.
package latch_cond_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } db_state_t;

   localparam int unsigned DEBOUNCE_MIN = 2;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce FSM with stability counter,
// registered debounced level and a one-cycle pulse on accepted press.
module debounce_channel
   import latch_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   db_state_t              state_q;
   logic [CntW-1:0]        cnt_q;
   logic                   level_q;
   logic                   rise_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // Counter restarts on every state entry so each wait phase measures a fresh run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         unique case (state_q)
            RELEASED: begin
               if (synced) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!synced) begin
                  state_q <= RELEASED;
                  cnt_q   <= '0;
               end else if (cnt_q == CntLast) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
                  level_q <= 1'b1;
                  rise_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            PRESSED: begin
               if (!synced) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (synced) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CntLast) begin
                  state_q <= RELEASED;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= RELEASED;
               cnt_q   <= '0;
               level_q <= 1'b0;
            end
         endcase
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/latch_input_debouncer.sv
// Debounces set/clear buttons into mutually exclusive active-low drives
// for a NAND sr_latch; both drives release while both buttons are held.
module latch_input_debouncer
   import latch_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_set_raw,
   input  logic btn_clr_raw,
   output logic set_n,
   output logic rst_out_n,
   output logic set_evt,
   output logic clr_evt,
   output logic conflict
);

   if (DEBOUNCE_CYCLES < DEBOUNCE_MIN) begin : gen_db_check
      $error("DEBOUNCE_CYCLES must be at least %0d", DEBOUNCE_MIN);
   end

   if (SYNC_STAGES < 2) begin : gen_sync_check
      $error("SYNC_STAGES must be at least 2");
   end

   logic set_db;
   logic set_rise;
   logic clr_db;
   logic clr_rise;

   logic set_n_q;
   logic rst_out_n_q;
   logic set_evt_q;
   logic clr_evt_q;
   logic conflict_q;

   debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_set_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_set_raw),
      .level(set_db),
      .rise (set_rise)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_clr_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_clr_raw),
      .level(clr_db),
      .rise (clr_rise)
   );

   // A drive is only asserted when the opposite channel is released, so the
   // latch can never see S and R low together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_n_q     <= 1'b1;
         rst_out_n_q <= 1'b1;
         set_evt_q   <= 1'b0;
         clr_evt_q   <= 1'b0;
         conflict_q  <= 1'b0;
      end else begin
         set_n_q     <= ~(set_db & ~clr_db);
         rst_out_n_q <= ~(clr_db & ~set_db);
         set_evt_q   <= set_rise;
         clr_evt_q   <= clr_rise;
         conflict_q  <= set_db & clr_db;
      end
   end

   assign set_n     = set_n_q;
   assign rst_out_n = rst_out_n_q;
   assign set_evt   = set_evt_q;
   assign clr_evt   = clr_evt_q;
   assign conflict  = conflict_q;

endmodule

// File: tb/tb_latch_input_debouncer.sv
// Randomized and directed bench for latch_input_debouncer against a
// run-length reference model of the debounce rules.
module tb_latch_input_debouncer;

   localparam int unsigned D = 4;
   localparam int unsigned S = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_set_raw = 1'b0;
   logic btn_clr_raw = 1'b0;
   logic set_n, rst_out_n, set_evt, clr_evt, conflict;

   int n_checks = 0;
   int n_errors = 0;
   int set_evt_cnt = 0;
   int clr_evt_cnt = 0;

   // Reference model state
   bit q_raw_s[$];
   bit q_raw_c[$];
   bit db[2];
   int unsigned run[2];
   bit rise[2];
   bit m_set_n, m_rst_out_n, m_set_evt, m_clr_evt, m_conflict;

   latch_input_debouncer #(
      .DEBOUNCE_CYCLES(D),
      .SYNC_STAGES    (S)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_set_raw(btn_set_raw),
      .btn_clr_raw(btn_clr_raw),
      .set_n      (set_n),
      .rst_out_n  (rst_out_n),
      .set_evt    (set_evt),
      .clr_evt    (clr_evt),
      .conflict   (conflict)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q_raw_s = {};
      q_raw_c = {};
      for (int i = 0; i < int'(S); i++) begin
         q_raw_s.push_back(1'b0);
         q_raw_c.push_back(1'b0);
      end
      for (int c = 0; c < 2; c++) begin
         db[c] = 1'b0;
         run[c] = 0;
         rise[c] = 1'b0;
      end
      m_set_n = 1'b1;
      m_rst_out_n = 1'b1;
      m_set_evt = 1'b0;
      m_clr_evt = 1'b0;
      m_conflict = 1'b0;
   endfunction

   // A level flips once D+1 consecutive synced samples disagree with it:
   // the first one leaves the idle state, then D more confirm the change.
   function automatic void model_edge();
      bit samp[2];
      m_set_n     = !(db[0] && !db[1]);
      m_rst_out_n = !(db[1] && !db[0]);
      m_conflict  = db[0] && db[1];
      m_set_evt   = rise[0];
      m_clr_evt   = rise[1];
      samp[0] = q_raw_s.pop_front();
      samp[1] = q_raw_c.pop_front();
      q_raw_s.push_back(btn_set_raw);
      q_raw_c.push_back(btn_clr_raw);
      for (int c = 0; c < 2; c++) begin
         rise[c] = 1'b0;
         if (samp[c] != db[c]) begin
            run[c]++;
            if (run[c] == D + 1) begin
               db[c] = samp[c];
               run[c] = 0;
               rise[c] = samp[c];
            end
         end else begin
            run[c] = 0;
         end
      end
   endfunction

   task automatic check_outputs(input string where);
      check_eq({where, ".set_n"}, set_n, m_set_n);
      check_eq({where, ".rst_out_n"}, rst_out_n, m_rst_out_n);
      check_eq({where, ".set_evt"}, set_evt, m_set_evt);
      check_eq({where, ".clr_evt"}, clr_evt, m_clr_evt);
      check_eq({where, ".conflict"}, conflict, m_conflict);
   endtask

   // Called on a falling edge; drives inputs, advances one clock, checks.
   task automatic step(input bit s, input bit c);
      btn_set_raw = s;
      btn_clr_raw = c;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (set_evt) set_evt_cnt++;
      if (clr_evt) clr_evt_cnt++;
      check_outputs("step");
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("rst_now");
      repeat (3) @(negedge clk);
      check_outputs("rst_hold");
      rst_n = 1'b1;
   endtask

   // Steps with fixed inputs until the selected output condition appears;
   // returns the edge index after the first sampling edge, or -1 on timeout.
   task automatic measure(input bit s, input bit c, input int which, output int lat);
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         step(s, c);
         if ((which == 0 && set_n == 1'b0) || (which == 1 && conflict == 1'b1) ||
             (which == 2 && rst_out_n == 1'b0)) begin
            lat = i - 1;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int seg_len;
      bit rs, rc;

      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int seg_len;
      bit rs, rc;
      model_reset();
      @(negedge clk);
      do_reset();
      repeat (3) step(1'b0, 1'b0);

      // Clean set press
      set_evt_cnt = 0;
      measure(1'b1, 1'b0, 0, lat);
      check_eq("press_latency", lat, S + D + 1);
      repeat (6) step(1'b1, 1'b0);
      check_eq("press_evt_count", set_evt_cnt, 1);
      repeat (12) step(1'b0, 1'b0);
      check_eq("release_set_n", set_n, 1);

      // Bounce rejection
      set_evt_cnt = 0;
      for (int i = 0; i < 40; i++) step((i % 4) != 3, 1'b0);
      check_eq("bounce_evt_count", set_evt_cnt, 0);
      measure(1'b1, 1'b0, 0, lat);
      check_eq("bounce_then_hold_latency", lat, S + D + 1);
      repeat (12) step(1'b0, 1'b0);

      // Simultaneous press
      set_evt_cnt = 0;
      clr_evt_cnt = 0;
      measure(1'b1, 1'b1, 1, lat);
      check_eq("simul_latency", lat, S + D + 1);
      check_eq("simul_set_n", set_n, 1);
      check_eq("simul_rst_out_n", rst_out_n, 1);
      repeat (6) step(1'b1, 1'b1);
      check_eq("simul_set_evt_count", set_evt_cnt, 1);
      check_eq("simul_clr_evt_count", clr_evt_cnt, 1);
      repeat (12) step(1'b0, 1'b0);

      // Overlap: set held, clear added, set released
      repeat (10) step(1'b1, 1'b0);
      check_eq("overlap_set_n_low", set_n, 0);
      measure(1'b1, 1'b1, 1, lat);
      check_eq("overlap_conflict_latency", lat, S + D + 1);
      check_eq("overlap_set_n_high", set_n, 1);
      measure(1'b0, 1'b1, 2, lat);
      check_eq("overlap_release_latency", lat, S + D + 1);
      check_eq("overlap_conflict_clear", conflict, 0);
      repeat (12) step(1'b0, 1'b0);

      // Reset mid-count, then full latency with raw still high
      repeat (5) step(1'b1, 1'b0);
      do_reset();
      measure(1'b1, 1'b0, 0, lat);
      check_eq("post_reset_latency", lat, S + D + 1);
      // Reset while pressed must clear drives without a clock
      repeat (3) step(1'b1, 1'b0);
      do_reset();
      check_eq("reset_pressed_set_n", set_n, 1);
      set_evt_cnt = 0;
      repeat (4) step(1'b0, 1'b0);
      check_eq("no_residual_evt", set_evt_cnt, 0);

      // Randomized bouncing on both channels
      for (int n = 0; n < 900; ) begin
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         seg_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14))
                                               : int'($urandom_range(1, 5));
         for (int j = 0; j < seg_len; j++) begin
            step(rs, rc);
            n++;
         end
      end
      repeat (12) step(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
